// File: rtl/led_pwm_dimmer.sv
`default_nettype none
// ============================================================================
//  Module      : led_pwm_dimmer
//  Description : Downstream PWM dimming stage for the LED peripheral.
//                Takes the 16-bit LED register value and snoops the CPU write
//                bus for its own duty and control registers. It produces
//                glitch-free, dimmed LED pins. There is one clock domain, and
//                all outputs are registered.
//  Optional    : `define LED_BLINK_EN adds the blink feature (ctrl bit1).
//  Ports       : clk           - system clock, rising edge
//                rst           - asynchronous reset, active-low
//                led_in[15:0]  - LED register value from the LED peripheral
//                wr_en         - bus write strobe, sampled on clk
//                data_address  - bus address [7:0]
//                write_data    - bus write data [7:0]
//                led_out[15:0] - dimmed LED pins (registered)
//                period_done   - one-cycle pulse at each PWM period end
//  Revision    : 1.0 - initial release
// ============================================================================
module led_pwm_dimmer #(
  parameter int         PRESCALE      = 4,
  parameter logic [7:0] DUTY_ADDR     = 8'h02,
  parameter logic [7:0] CTRL_ADDR     = 8'h03,
  parameter logic [7:0] DUTY_RESET    = 8'h80,
  parameter int         BLINK_PERIODS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] led_in,
  input  logic        wr_en,
  input  logic [7:0]  data_address,
  input  logic [7:0]  write_data,
  output logic [15:0] led_out,
  output logic        period_done
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int                 c_pre_w   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [c_pre_w-1:0] c_pre_max = c_pre_w'(PRESCALE - 1);
  localparam logic [7:0]         c_ctrl_reset = 8'h01;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [c_pre_w-1:0] r_prescale;
  logic [7:0]         r_pwm_cnt;
  logic [7:0]         r_duty_shadow;
  logic [7:0]         r_duty_active;
  logic [7:0]         r_ctrl;
  logic [15:0]        r_led_out;
  logic               r_period_done;

  // --------------------------------------------------------------------------
  // Combinational decode
  // --------------------------------------------------------------------------
  logic        w_step;
  logic        w_boundary;
  logic        w_duty_wr;
  logic        w_ctrl_wr;
  logic        w_on;
  logic        w_pwm_en;
  logic        w_blank;
  logic [15:0] w_led_next;

  assign w_step     = (r_prescale == c_pre_max);
  assign w_boundary = w_step && (r_pwm_cnt == 8'hFF);
  assign w_duty_wr  = wr_en && (data_address == DUTY_ADDR);
  assign w_ctrl_wr  = wr_en && (data_address == CTRL_ADDR);
  assign w_pwm_en   = r_ctrl[0];

  // Full scale (8'hFF) is forced fully on. Without this, the compare would
  // leave the LED dark in the one slot where pwm_cnt==255.
  assign w_on = (r_duty_active == 8'hFF) || (r_pwm_cnt < r_duty_active);

  // --------------------------------------------------------------------------
  // Prescaler: PRESCALE clocks per PWM step. With PRESCALE==1 the compare is
  // always true, so the counter stays at zero and every clock is a step.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_prescale <= '0;
    end else if (w_step) begin
      r_prescale <= '0;
    end else begin
      r_prescale <= r_prescale + c_pre_w'(1);
    end
  end

  // --------------------------------------------------------------------------
  // PWM phase counter. It runs freely regardless of pwm_en, so toggling
  // bypass never disturbs the phase. It wraps naturally from 255 to 0.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pwm_cnt <= 8'h00;
    end else if (w_step) begin
      r_pwm_cnt <= r_pwm_cnt + 8'd1;
    end
  end

  // --------------------------------------------------------------------------
  // Bus-visible registers.
  // The shadow register takes writes at any time. The active duty only
  // reloads at a period boundary, so a period is never cut short.
  // A write that lands on the boundary edge goes straight into the active
  // duty; otherwise the new value would be lost for a whole period.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_duty_shadow <= DUTY_RESET;
      r_duty_active <= DUTY_RESET;
      r_ctrl        <= c_ctrl_reset;
    end else begin
      if (w_duty_wr) begin
        r_duty_shadow <= write_data;
      end
      if (w_boundary) begin
        r_duty_active <= w_duty_wr ? write_data : r_duty_shadow;
      end
      if (w_ctrl_wr) begin
        r_ctrl <= write_data;
      end
    end
  end

`ifdef LED_BLINK_EN
  // --------------------------------------------------------------------------
  // Blink: counts period boundaries and toggles visibility every
  // BLINK_PERIODS boundaries. While blink_en is clear, the block is held in
  // its visible, zero-count state. This ensures that re-enabling blink always
  // starts with a full visible phase.
  // --------------------------------------------------------------------------
  localparam int                   c_blink_w   = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;
  localparam logic [c_blink_w-1:0] c_blink_max = c_blink_w'(BLINK_PERIODS - 1);

  logic [c_blink_w-1:0] r_blink_cnt;
  logic                 r_blink_phase;
  logic                 w_blink_en;
  logic                 w_unused;

  assign w_blink_en = r_ctrl[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b1;
    end else if (!w_blink_en) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b1;
    end else if (w_boundary) begin
      if (r_blink_cnt == c_blink_max) begin
        r_blink_cnt   <= '0;
        r_blink_phase <= ~r_blink_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + c_blink_w'(1);
      end
    end
  end

  assign w_blank  = w_blink_en && !r_blink_phase;
  // Upper control bits are stored for software readback only.
  assign w_unused = &{1'b0, r_ctrl[7:2]};
`else
  logic w_unused;

  assign w_blank  = 1'b0;
  // Upper control bits are stored only; blink period is not built.
  assign w_unused = &{1'b0, r_ctrl[7:1], (BLINK_PERIODS != 0)};
`endif

  // --------------------------------------------------------------------------
  // Output selection. Outputs are registered so the pins stay glitch free.
  // --------------------------------------------------------------------------
  always_comb begin
    w_led_next = led_in;
    if (w_blank) begin
      w_led_next = 16'h0000;
    end else if (w_pwm_en) begin
      w_led_next = led_in & {16{w_on}};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_led_out     <= 16'h0000;
      r_period_done <= 1'b0;
    end else begin
      r_led_out     <= w_led_next;
      r_period_done <= w_boundary;
    end
  end

  assign led_out     = r_led_out;
  assign period_done = r_period_done;

endmodule
`default_nettype wire
